// File: rtl/replacement_ctrl_pkg.sv
// Shared types for the replacement-policy sequencer.
//   ctrl_state_e : controller FSM states (idle, hit update, refill wait, miss update)
package replacement_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StHitUpd  = 2'd1,
        StMissReq = 2'd2,
        StMissUpd = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/rep_sat_counter.sv
// Saturating event counter with synchronous clear.
//   i_clk, i_reset : clock, asynchronous active-high reset
//   i_inc          : count one event this cycle
//   i_clr          : synchronous clear, wins over a same-cycle increment
//   o_cnt          : current count, sticks at all-ones
module rep_sat_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_inc,
    input  logic             i_clr,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_d;

    always_comb begin
        w_cnt_d = r_cnt;
        if (i_clr) begin
            w_cnt_d = '0;
        end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
            w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_d;
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/replacement_ctrl.sv
// Replacement-policy sequencer: sits between tag compare and the policy block.
// Hits mark the hit way MRU; misses capture the policy victim, request a refill and
// mark the victim MRU once the refill is acknowledged. Also keeps hit/miss statistics.
//   i_clk, i_reset        : clock, asynchronous active-high reset
//   i_req_valid/line/way_hit, o_req_ready : lookup result handshake (way_hit==0 is a miss)
//   o_pol_write_en/line_addr/way_hit      : policy state update port
//   i_pol_way_sel/_bin    : policy victim for o_pol_line_addr (one-hot / binary)
//   o_refill_req/line/way, i_refill_ack   : back-end refill handshake
//   o_hit_err             : sticky flag, a lookup reported more than one hit way
//   i_cnt_clr, o_hit_cnt, o_miss_cnt      : saturating statistics counters
module replacement_ctrl
    import replacement_ctrl_pkg::*;
#(
    parameter int unsigned N_WAYS     = 8,
    parameter int unsigned LINE_OFF_W = 7,
    parameter int unsigned NWAY_W     = $clog2(N_WAYS),
    parameter int unsigned CNT_W      = 32
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_req_valid,
    input  logic [LINE_OFF_W-1:0] i_req_line,
    input  logic [N_WAYS-1:0]     i_way_hit,
    output logic                  o_req_ready,
    output logic                  o_pol_write_en,
    output logic [LINE_OFF_W-1:0] o_pol_line_addr,
    output logic [N_WAYS-1:0]     o_pol_way_hit,
    input  logic [N_WAYS-1:0]     i_pol_way_sel,
    input  logic [NWAY_W-1:0]     i_pol_way_sel_bin,
    output logic                  o_refill_req,
    output logic [LINE_OFF_W-1:0] o_refill_line,
    output logic [NWAY_W-1:0]     o_refill_way,
    input  logic                  i_refill_ack,
    output logic                  o_hit_err,
    input  logic                  i_cnt_clr,
    output logic [CNT_W-1:0]      o_hit_cnt,
    output logic [CNT_W-1:0]      o_miss_cnt
);

    ctrl_state_e             r_state, w_state_d;
    logic [LINE_OFF_W-1:0]   r_line;
    logic [N_WAYS-1:0]       r_way_oh;
    logic [NWAY_W-1:0]       r_way_bin;
    logic                    r_hit_err;

    logic w_accept;
    logic w_is_hit;
    logic w_multi_hit;

    assign w_accept    = (r_state == StIdle) && i_req_valid;
    assign w_is_hit    = |i_way_hit;
    // Clearing the lowest set bit leaves something only if more than one bit was set.
    assign w_multi_hit = |(i_way_hit & (i_way_hit - N_WAYS'(1)));

    // Next-state logic and outputs.
    always_comb begin
        w_state_d       = r_state;
        o_req_ready     = 1'b0;
        o_pol_write_en  = 1'b0;
        o_pol_way_hit   = '0;
        o_refill_req    = 1'b0;
        // Outside idle the policy keeps looking at the stored line so a victim read stays
        // coherent with the line being updated.
        o_pol_line_addr = r_line;

        unique case (r_state)
            StIdle: begin
                o_req_ready     = 1'b1;
                o_pol_line_addr = i_req_line;
                if (i_req_valid) begin
                    w_state_d = w_is_hit ? StHitUpd : StMissReq;
                end
            end
            StHitUpd: begin
                o_pol_write_en = 1'b1;
                o_pol_way_hit  = r_way_oh;
                w_state_d      = StIdle;
            end
            StMissReq: begin
                o_refill_req = 1'b1;
                if (i_refill_ack) begin
                    w_state_d = StMissUpd;
                end
            end
            StMissUpd: begin
                o_pol_write_en = 1'b1;
                o_pol_way_hit  = r_way_oh;
                w_state_d      = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    // Refill address is only meaningful while the request is up.
    assign o_refill_line = o_refill_req ? r_line : '0;
    assign o_refill_way  = o_refill_req ? r_way_bin : '0;
    assign o_hit_err     = r_hit_err;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_line    <= '0;
            r_way_oh  <= '0;
            r_way_bin <= '0;
            r_hit_err <= 1'b0;
        end else begin
            r_state <= w_state_d;
            if (w_accept) begin
                r_line <= i_req_line;
                if (w_is_hit) begin
                    // Multi-hot vectors are forwarded unchanged; only the flag records them.
                    r_way_oh <= i_way_hit;
                end else begin
                    r_way_oh  <= i_pol_way_sel;
                    r_way_bin <= i_pol_way_sel_bin;
                end
            end
            if (w_accept && w_multi_hit) begin
                r_hit_err <= 1'b1;
            end
        end
    end

    rep_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_accept && w_is_hit),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_hit_cnt)
    );

    rep_sat_counter #(
        .CNT_W (CNT_W)
    ) u_miss_cnt (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_inc   (w_accept && !w_is_hit),
        .i_clr   (i_cnt_clr),
        .o_cnt   (o_miss_cnt)
    );

endmodule

// File: tb/tb_replacement_ctrl.sv
// Directed self-checking bench for replacement_ctrl (8 ways, 4-bit counters).
module tb_replacement_ctrl;

    localparam int unsigned N_WAYS     = 8;
    localparam int unsigned LINE_OFF_W = 7;
    localparam int unsigned NWAY_W     = 3;
    localparam int unsigned CNT_W      = 4;

    logic                  clk;
    logic                  reset;
    logic                  req_valid;
    logic [LINE_OFF_W-1:0] req_line;
    logic [N_WAYS-1:0]     way_hit;
    logic                  req_ready;
    logic                  pol_write_en;
    logic [LINE_OFF_W-1:0] pol_line_addr;
    logic [N_WAYS-1:0]     pol_way_hit;
    logic [N_WAYS-1:0]     pol_way_sel;
    logic [NWAY_W-1:0]     pol_way_sel_bin;
    logic                  refill_req;
    logic [LINE_OFF_W-1:0] refill_line;
    logic [NWAY_W-1:0]     refill_way;
    logic                  refill_ack;
    logic                  hit_err;
    logic                  cnt_clr;
    logic [CNT_W-1:0]      hit_cnt;
    logic [CNT_W-1:0]      miss_cnt;

    int total = 0;
    int bad   = 0;

    replacement_ctrl #(
        .N_WAYS     (N_WAYS),
        .LINE_OFF_W (LINE_OFF_W),
        .NWAY_W     (NWAY_W),
        .CNT_W      (CNT_W)
    ) dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_req_valid       (req_valid),
        .i_req_line        (req_line),
        .i_way_hit         (way_hit),
        .o_req_ready       (req_ready),
        .o_pol_write_en    (pol_write_en),
        .o_pol_line_addr   (pol_line_addr),
        .o_pol_way_hit     (pol_way_hit),
        .i_pol_way_sel     (pol_way_sel),
        .i_pol_way_sel_bin (pol_way_sel_bin),
        .o_refill_req      (refill_req),
        .o_refill_line     (refill_line),
        .o_refill_way      (refill_way),
        .i_refill_ack      (refill_ack),
        .o_hit_err         (hit_err),
        .i_cnt_clr         (cnt_clr),
        .o_hit_cnt         (hit_cnt),
        .o_miss_cnt        (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs change and outputs are sampled here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_hit(input logic [LINE_OFF_W-1:0] line, input logic [N_WAYS-1:0] hv);
        req_valid = 1'b1;
        req_line  = line;
        way_hit   = hv;
        tick();
        req_valid = 1'b0;
        way_hit   = '0;
        tick();
    endtask

    initial begin
        reset           = 1'b1;
        req_valid       = 1'b0;
        req_line        = '0;
        way_hit         = '0;
        pol_way_sel     = '0;
        pol_way_sel_bin = '0;
        refill_ack      = 1'b0;
        cnt_clr         = 1'b0;
        #2;
        check("rst_ready",    32'(req_ready),    32'd1);
        check("rst_wen",      32'(pol_write_en), 32'd0);
        check("rst_refill",   32'(refill_req),   32'd0);
        check("rst_hit_err",  32'(hit_err),      32'd0);
        check("rst_hit_cnt",  32'(hit_cnt),      32'd0);
        check("rst_miss_cnt", 32'(miss_cnt),     32'd0);
        check("rst_way_hit",  32'(pol_way_hit),  32'd0);
        #20;
        reset = 1'b0;
        tick();

        // Hit on line 5, way 2.
        req_valid = 1'b1;
        req_line  = 7'd5;
        way_hit   = 8'h04;
        #1;
        check("idle_addr_comb", 32'(pol_line_addr), 32'd5);
        tick();
        req_valid = 1'b0;
        req_line  = 7'd33;
        way_hit   = '0;
        check("hit_wen",     32'(pol_write_en),  32'd1);
        check("hit_addr",    32'(pol_line_addr), 32'd5);
        check("hit_way",     32'(pol_way_hit),   32'h04);
        check("hit_busy",    32'(req_ready),     32'd0);
        check("hit_cnt_1",   32'(hit_cnt),       32'd1);
        tick();
        check("hit_ready",   32'(req_ready),     32'd1);
        check("hit_wen_off", 32'(pol_write_en),  32'd0);
        check("hit_way_off", 32'(pol_way_hit),   32'd0);

        // Miss on line 9, victim way 4; ack arrives after 6 MISS_REQ cycles.
        req_valid       = 1'b1;
        req_line        = 7'd9;
        pol_way_sel     = 8'h10;
        pol_way_sel_bin = 3'd4;
        tick();
        req_valid       = 1'b0;
        req_line        = 7'd0;
        pol_way_sel     = 8'h01;
        pol_way_sel_bin = 3'd0;
        check("miss_req",      32'(refill_req),    32'd1);
        check("miss_line",     32'(refill_line),   32'd9);
        check("miss_way",      32'(refill_way),    32'd4);
        check("miss_busy",     32'(req_ready),     32'd0);
        check("miss_no_wen",   32'(pol_write_en),  32'd0);
        check("miss_addr",     32'(pol_line_addr), 32'd9);
        check("miss_cnt_1",    32'(miss_cnt),      32'd1);
        for (int i = 0; i < 5; i++) tick();
        check("miss_req_held", 32'(refill_req),    32'd1);
        check("miss_way_held", 32'(refill_way),    32'd4);
        refill_ack = 1'b1;
        tick();
        refill_ack = 1'b0;
        check("mupd_wen",      32'(pol_write_en),  32'd1);
        check("mupd_way",      32'(pol_way_hit),   32'h10);
        check("mupd_addr",     32'(pol_line_addr), 32'd9);
        check("mupd_req_off",  32'(refill_req),    32'd0);
        check("mupd_busy",     32'(req_ready),     32'd0);
        tick();
        check("miss_ready",    32'(req_ready),     32'd1);
        check("miss_wen_off",  32'(pol_write_en),  32'd0);

        // Miss with ack in the very first MISS_REQ cycle.
        req_valid       = 1'b1;
        req_line        = 7'd3;
        pol_way_sel     = 8'h80;
        pol_way_sel_bin = 3'd7;
        tick();
        req_valid  = 1'b0;
        refill_ack = 1'b1;
        check("fast_req",     32'(refill_req),   32'd1);
        check("fast_way",     32'(refill_way),   32'd7);
        tick();
        refill_ack = 1'b0;
        check("fast_wen",     32'(pol_write_en), 32'd1);
        check("fast_pway",    32'(pol_way_hit),  32'h80);
        check("fast_no_dup",  32'(refill_req),   32'd0);
        tick();
        check("fast_ready",   32'(req_ready),    32'd1);
        check("fast_req_off", 32'(refill_req),   32'd0);
        check("miss_cnt_2",   32'(miss_cnt),     32'd2);

        // Stray ack while idle is ignored.
        refill_ack = 1'b1;
        tick();
        refill_ack = 1'b0;
        check("stray_ack_ready",  32'(req_ready),  32'd1);
        check("stray_ack_refill", 32'(refill_req), 32'd0);

        // Multi-hot hit is forwarded and flags hit_err, which stays sticky.
        req_valid = 1'b1;
        req_line  = 7'd2;
        way_hit   = 8'h05;
        tick();
        req_valid = 1'b0;
        way_hit   = '0;
        check("multi_way",    32'(pol_way_hit), 32'h05);
        check("multi_err",    32'(hit_err),     32'd1);
        tick();
        do_hit(7'd1, 8'h01);
        check("err_sticky",   32'(hit_err),     32'd1);
        check("hit_cnt_3",    32'(hit_cnt),     32'd3);

        // Clear, then saturate the 4-bit hit counter.
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        check("clr_hit",  32'(hit_cnt),  32'd0);
        check("clr_miss", 32'(miss_cnt), 32'd0);
        for (int i = 0; i < 16; i++) do_hit(7'(i), 8'h02);
        check("hit_sat",  32'(hit_cnt),  32'd15);
        // Clear wins over a same-cycle hit.
        req_valid = 1'b1;
        req_line  = 7'd7;
        way_hit   = 8'h20;
        cnt_clr   = 1'b1;
        tick();
        req_valid = 1'b0;
        way_hit   = '0;
        cnt_clr   = 1'b0;
        check("clr_wins", 32'(hit_cnt),  32'd0);
        tick();

        // Reset asserted mid-refill.
        req_valid       = 1'b1;
        req_line        = 7'd11;
        pol_way_sel     = 8'h02;
        pol_way_sel_bin = 3'd1;
        tick();
        req_valid = 1'b0;
        check("rr_req_up", 32'(refill_req), 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rr_req_drop", 32'(refill_req),   32'd0);
        check("rr_ready",    32'(req_ready),    32'd1);
        check("rr_no_wen",   32'(pol_write_en), 32'd0);
        check("rr_err_clr",  32'(hit_err),      32'd0);
        #3;
        refill_ack = 1'b1;
        reset      = 1'b0;
        tick();
        refill_ack = 1'b0;
        check("rr_post_wen",   32'(pol_write_en), 32'd0);
        check("rr_post_ready", 32'(req_ready),    32'd1);
        check("rr_post_req",   32'(refill_req),   32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
